// File: rtl/ex_iter_divider_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
// State encoding is 2-bit so debug taps and the hazard unit can read it directly.
package ex_iter_divider_pkg;

    localparam int DIV_DATA_W  = 32;
    localparam int DIV_CNT_W   = 5;
    // Cycles div_stall stays high for one divide: the accept cycle plus DATA_W steps.
    localparam int DIV_LATENCY = DIV_DATA_W + 1;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_iter_divider_if.sv
// ES <-> divider connection. The master modport is the ES side, the slave is the divider.
// Handshake: ES raises div_req with operands and holds it; div_res_valid marks results;
// div_ack in a valid cycle consumes them; div_flush cancels and wins over ack and accept.
interface ex_iter_divider_if
    import ex_iter_divider_pkg::*;
#(
    parameter int DATA_W = 32
) ();

    logic              div_req;
    logic              div_signed;
    logic [DATA_W-1:0] div_src1;
    logic [DATA_W-1:0] div_src2;
    logic              div_ack;
    logic              div_flush;
    logic              div_stall;
    logic              div_busy;
    logic              div_res_valid;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W-1:0] div_rem;
    div_state_e        dbg_state;

    modport master (
        output div_req, div_signed, div_src1, div_src2, div_ack, div_flush,
        input  div_stall, div_busy, div_res_valid, div_quot, div_rem, dbg_state
    );

    modport slave (
        input  div_req, div_signed, div_src1, div_src2, div_ack, div_flush,
        output div_stall, div_busy, div_res_valid, div_quot, div_rem, dbg_state
    );

endinterface

// File: rtl/ex_iter_divider_restore_step.sv
// One radix-2 restoring division step on magnitudes: shift {rem,quot} left by one,
// subtract the divisor from the widened partial remainder and keep it if non-negative.
module div_restore_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quot,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quot_next
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;
    logic            trial_neg;

    // One extra bit so the shifted remainder (< 2*divisor) never overflows the trial.
    assign shifted   = {rem, quot[DATA_W-1]};
    assign trial     = shifted - {1'b0, divisor};
    assign trial_neg = trial[DATA_W];

    assign rem_next  = trial_neg ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quot_next = {quot[DATA_W-2:0], ~trial_neg};

endmodule

// File: rtl/ex_iter_divider.sv
// Multi-cycle radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu in EX.
// Fixed latency, no early-out; quotient and remainder are returned together.
module ex_iter_divider
    import ex_iter_divider_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input logic         clk,
    input logic         resetn,
    ex_iter_divider_if.slave bus
);

    div_state_e        state;
    div_state_e        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] divisor_q;
    logic              q_sign;
    logic              r_sign;
    logic [DATA_W-1:0] quot_out;
    logic [DATA_W-1:0] rem_out;

    logic              accept;
    logic              last_step;
    logic              src1_neg;
    logic              src2_neg;
    logic [DATA_W-1:0] src1_abs;
    logic [DATA_W-1:0] src2_abs;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quot_nx;

    assign accept    = (state == DIV_ST_IDLE) && bus.div_req && !bus.div_flush;
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    // Magnitudes use plain wrap-around negate, so 0x80000000 stays 0x80000000.
    assign src1_neg = bus.div_signed && bus.div_src1[DATA_W-1];
    assign src2_neg = bus.div_signed && bus.div_src2[DATA_W-1];
    assign src1_abs = src1_neg ? -bus.div_src1 : bus.div_src1;
    assign src2_abs = src2_neg ? -bus.div_src2 : bus.div_src2;

    div_restore_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (divisor_q),
        .rem_next  (rem_nx),
        .quot_next (quot_nx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.div_flush) begin
            state_next = DIV_ST_IDLE;
        end else begin
            case (state)
                DIV_ST_IDLE: if (accept)       state_next = DIV_ST_BUSY;
                DIV_ST_BUSY: if (last_step)    state_next = DIV_ST_DONE;
                DIV_ST_DONE: if (bus.div_ack)  state_next = DIV_ST_IDLE;
                default:                       state_next = DIV_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            quot_out  <= '0;
            rem_out   <= '0;
        end else begin
            if (accept) begin
                // Dividend magnitude enters the low half and is shifted out bit by bit.
                rem_q     <= '0;
                quot_q    <= src1_abs;
                divisor_q <= src2_abs;
                q_sign    <= bus.div_signed && (bus.div_src1[DATA_W-1] ^ bus.div_src2[DATA_W-1]);
                r_sign    <= src1_neg;
                cnt       <= '0;
            end else if (state == DIV_ST_BUSY && !bus.div_flush) begin
                rem_q  <= rem_nx;
                quot_q <= quot_nx;
                cnt    <= cnt + 1'b1;
                if (last_step) begin
                    quot_out <= q_sign ? -quot_nx : quot_nx;
                    rem_out  <= r_sign ? -rem_nx  : rem_nx;
                end
            end
        end
    end

    assign bus.div_busy      = (state != DIV_ST_IDLE);
    assign bus.div_res_valid = (state == DIV_ST_DONE);
    assign bus.div_stall     = bus.div_req && (state != DIV_ST_DONE);
    assign bus.div_quot      = quot_out;
    assign bus.div_rem       = rem_out;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_ex_iter_divider.sv
// Bench for ex_iter_divider: directed corner cases, random operands against an
// arithmetic reference, flush, asynchronous reset mid-divide and back-to-back issue.
module tb_ex_iter_divider;
    import ex_iter_divider_pkg::*;

    localparam int W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_iter_divider_if #(.DATA_W(W)) bus ();

    ex_iter_divider #(
        .DATA_W (W),
        .CNT_W  (5)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: language-level division, with the divider's defined corner results.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = (s && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic idle_inputs();
        bus.div_req    = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_src1   = '0;
        bus.div_src2   = '0;
        bus.div_ack    = 1'b0;
        bus.div_flush  = 1'b0;
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.div_req    = 1'b1;
        bus.div_signed = s;
        bus.div_src1   = a;
        bus.div_src2   = b;
    endtask

    // Called just after a falling edge; counts stall cycles until the result shows up.
    task automatic wait_result(output int cyc, output bit timed_out);
        cyc       = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.div_res_valid) begin
                timed_out = 1'b0;
                break;
            end
            if (bus.div_stall) cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           cyc;
        bit           to;
        ref_div(a, b, s, eq, er);
        @(negedge clk);
        start_div(a, b, s);
        wait_result(cyc, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL %s timeout: res_valid=0 after 100 cycles, required 1", name);
            bus.div_flush = 1'b1;
            bus.div_req   = 1'b0;
            @(negedge clk);
            bus.div_flush = 1'b0;
            return;
        end
        n_checks++;
        if (cyc !== DIV_LATENCY) begin
            n_fail++;
            $display("FAIL %s latency: stall cycles=%0d required %0d", name, cyc, DIV_LATENCY);
        end
        n_checks++;
        if (bus.div_quot !== eq || bus.div_rem !== er) begin
            n_fail++;
            $display("FAIL %s result (a=%h b=%h s=%0d): quot=%h rem=%h required quot=%h rem=%h",
                     name, a, b, s, bus.div_quot, bus.div_rem, eq, er);
        end
        bus.div_src1 = ~a;
        bus.div_src2 = ~b;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus.div_res_valid !== 1'b1 || bus.div_quot !== eq || bus.div_rem !== er
            || bus.div_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold: valid=%b stall=%b quot=%h rem=%h required 1 0 %h %h",
                     name, bus.div_res_valid, bus.div_stall, bus.div_quot, bus.div_rem, eq, er);
        end
        bus.div_ack = 1'b1;
        bus.div_req = 1'b0;
        @(negedge clk);
        bus.div_ack = 1'b0;
        #1;
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack: busy=%b valid=%b required 0 0", name, bus.div_busy,
                     bus.div_res_valid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_res_valid !== 1'b0 || bus.div_stall !== 1'b0
            || bus.div_quot !== '0 || bus.div_rem !== '0 || bus.dbg_state !== DIV_ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b stall=%b quot=%h rem=%h required all 0",
                     bus.div_busy, bus.div_res_valid, bus.div_stall, bus.div_quot, bus.div_rem);
        end
        @(negedge clk);
        resetn = 1'b1;
        // A request raised together with a flush is seen on stall but never accepted.
        bus.div_req   = 1'b1;
        bus.div_flush = 1'b1;
        #1;
        n_checks++;
        if (bus.div_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_tracks_req: stall=%b required 1", bus.div_stall);
        end
        @(negedge clk);
        n_checks++;
        if (bus.div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_accept: busy=%b required 0", bus.div_busy);
        end
        idle_inputs();
    endtask

    task automatic test_directed();
        run_one("u_100_7",    32'd100,        32'd7,          1'b0);
        run_one("s_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1);
        run_one("s_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1);
        run_one("s_overflow", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1);
        run_one("u_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0);
        run_one("u_div0",     32'h0000_1234,  32'd0,          1'b0);
        run_one("s_m5_div0",  32'hFFFF_FFFB,  32'd0,          1'b1);
        run_one("u_small_big", 32'd5,         32'hFFFF_FFF0,  1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = -W'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            run_one("random", a, b, s);
        end
    endtask

    task automatic test_flush();
        bit seen_valid;
        @(negedge clk);
        start_div(32'h0000_1234, 32'd7, 1'b0);
        @(negedge clk);
        repeat (9) @(negedge clk);
        bus.div_flush = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_to_idle: busy=%b valid=%b required 0 0", bus.div_busy,
                     bus.div_res_valid);
        end
        bus.div_flush = 1'b0;
        bus.div_req   = 1'b0;
        seen_valid    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.div_res_valid || bus.div_busy) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid) begin
            n_fail++;
            $display("FAIL flush_no_result: activity after flush=1 required 0");
        end
        run_one("after_flush_20_3", 32'd20, 32'd3, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_div(32'd1000, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_res_valid !== 1'b0 || bus.div_quot !== '0
            || bus.div_rem !== '0 || bus.dbg_state !== DIV_ST_IDLE || bus.div_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b valid=%b quot=%h rem=%h stall=%b required 0 0 0 0 1",
                     bus.div_busy, bus.div_res_valid, bus.div_quot, bus.div_rem, bus.div_stall);
        end
        bus.div_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_one("after_reset", 32'hFFFF_FF9C, 32'd7, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           cyc;
        bit           to;
        @(negedge clk);
        start_div(32'd123456, 32'd789, 1'b0);
        wait_result(cyc, to);
        ref_div(32'd123456, 32'd789, 1'b0, eq, er);
        n_checks++;
        if (to || bus.div_quot !== eq || bus.div_rem !== er) begin
            n_fail++;
            $display("FAIL b2b_first: timeout=%0d quot=%h rem=%h required 0 %h %h", to,
                     bus.div_quot, bus.div_rem, eq, er);
        end
        bus.div_ack = 1'b1;
        start_div(32'hFFFF_8000, 32'd9, 1'b1);
        @(negedge clk);
        bus.div_ack = 1'b0;
        #1;
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy=%b stall=%b required 0 1", bus.div_busy,
                     bus.div_stall);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.div_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b required 1", bus.div_busy);
        end
        wait_result(cyc, to);
        ref_div(32'hFFFF_8000, 32'd9, 1'b1, eq, er);
        n_checks++;
        if (to || cyc !== DIV_LATENCY - 1 || bus.div_quot !== eq || bus.div_rem !== er) begin
            n_fail++;
            $display("FAIL b2b_second: timeout=%0d cycles=%0d quot=%h rem=%h required 0 %0d %h %h",
                     to, cyc, bus.div_quot, bus.div_rem, DIV_LATENCY - 1, eq, er);
        end
        bus.div_ack = 1'b1;
        bus.div_req = 1'b0;
        @(negedge clk);
        bus.div_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
